// File: rtl/multicycle_cpu_if.sv
// Instruction-fetch bus between multicycle_cpu (master) and instruction memory (slave).
// The CPU holds req/addr until memory answers with valid/rdata in the same cycle.
interface multicycle_cpu_if #(
  parameter int DATA_W = 16
) ();
  logic              req;
  logic [DATA_W-1:0] addr;
  logic              valid;
  logic [15:0]       rdata;

  modport master (output req, output addr, input valid, input rdata);
  modport slave  (input req, input addr, output valid, output rdata);
endinterface

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU: FETCH/DECODE/EXECUTE/WRITEBACK/HALT FSM, 4-entry register file, ALU.
// Optional feature macro MULTICYCLE_CPU_RETIRE_CNT_EN adds a saturating 32-bit 'retired' counter.
module multicycle_cpu #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 2
) (
  input  logic              clock,
  input  logic              reset,
  multicycle_cpu_if.master  imem,
  output logic [DATA_W-1:0] PC,
  output logic [15:0]       IR,
  output logic [DATA_W-1:0] ALUOut,
  output logic              halted
`ifdef MULTICYCLE_CPU_RETIRE_CNT_EN
  ,
  output logic [31:0]       retired
`endif
);

  localparam logic [DATA_W-1:0] STEP      = DATA_W'(PC_STEP);
  localparam logic [15:0]       HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] regs [4];
  logic [DATA_W-1:0] a_q, b_q, imm_q, target_q;
  logic [DATA_W-1:0] alu_result, imm_ext;
  logic [3:0]        op;
  logic [1:0]        rs, rt, rd;
  logic              is_rtype, is_addi, branch_taken;

  assign op      = IR[15:12];
  assign rs      = IR[11:10];
  assign rt      = IR[9:8];
  assign rd      = IR[7:6];
  assign imm_ext = {{(DATA_W-8){IR[7]}}, IR[7:0]};

  assign is_rtype     = (op <= 4'd4);
  assign is_addi      = (op == 4'd5);
  assign branch_taken = ((op == 4'd6) && (a_q == b_q)) || ((op == 4'd7) && (a_q != b_q));

  // Request is masked during reset so nothing is fetched before release.
  assign imem.req  = (state == S_FETCH) && !reset;
  assign imem.addr = PC;

  always_comb begin
    alu_result = '0;
    case (op)
      4'd0:       alu_result = a_q + b_q;
      4'd1:       alu_result = a_q - b_q;
      4'd2:       alu_result = a_q & b_q;
      4'd3:       alu_result = a_q | b_q;
      4'd4:       alu_result = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      4'd5:       alu_result = a_q + imm_q;
      4'd6, 4'd7: alu_result = a_q - b_q;
      default:    alu_result = '0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:     if (imem.valid) next_state = S_DECODE;
      S_DECODE:    next_state = (IR == HALT_WORD) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   next_state = S_WRITEBACK;
      S_WRITEBACK: next_state = S_FETCH;
      S_HALT:      next_state = S_HALT;
      default:     next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      PC       <= RESET_PC;
      IR       <= '0;
      ALUOut   <= '0;
      halted   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      target_q <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem.valid) IR <= imem.rdata;
        end
        S_DECODE: begin
          a_q   <= regs[rs];
          b_q   <= regs[rt];
          imm_q <= imm_ext;
          if (IR == HALT_WORD) halted <= 1'b1;
        end
        S_EXECUTE: begin
          ALUOut   <= alu_result;
          target_q <= PC + STEP + (imm_q << 1);
        end
        S_WRITEBACK: begin
          PC <= branch_taken ? target_q : (PC + STEP);
        end
        default: ;
      endcase
    end
  end

  // Registers change only on WRITEBACK, so a reset mid-instruction never leaves a partial write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (state == S_WRITEBACK) begin
      if (is_rtype)     regs[rd] <= ALUOut;
      else if (is_addi) regs[rt] <= ALUOut;
    end
  end

`ifdef MULTICYCLE_CPU_RETIRE_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                        retired <= '0;
    else if (state == S_WRITEBACK && retired != '1)   retired <= retired + 32'd1;
  end
`endif

endmodule
